dkong_pal_mix: RTL

- Pixel output stage directly downstream of the background VRAM/tile stage and the object (sprite) stage.
- Each pixel, it chooses between the object pixel and the background pixel. It then forms an 8-bit palette address, looks up two 256x4 colour PROMs (2E/2F) and drives registered, blanked RGB.
- The PROMs are loaded at start-up through the download port. The CPU palette bank is taken up only at vertical blank, so the bank never changes mid-frame.

---
 rtl/dkong_pkg.sv | 15 +
 rtl/dkong_col_prom.sv | 44 ++++
 rtl/dkong_dpram.sv | 28 ++
 rtl/dkong_pal_mix.sv | 107 ++++++++++
 4 files changed

// File: rtl/dkong_pkg.sv
// rtl/dkong_pkg.sv - shared constants for the Donkey Kong palette output stage
package dkong_pkg;

    localparam int PAL_ADDR_W = 8;
    localparam int PROM_DW    = 4;
    localparam int BANK_W     = 2;

    localparam int R_W = 3;
    localparam int G_W = 3;
    localparam int B_W = 2;

    localparam logic [7:0] DL_HI_2E = 8'hF0;
    localparam logic [7:0] DL_HI_2F = 8'hF1;

endpackage

// File: rtl/dkong_col_prom.sv
// rtl/dkong_col_prom.sv - colour PROM pair 2E/2F with download address decode
module dkong_col_prom
    import dkong_pkg::*;
(
    input  logic                    clk,
    input  logic [15:0]             dl_addr,
    input  logic                    dl_wr,
    input  logic [PROM_DW-1:0]      dl_data,
    input  logic [PAL_ADDR_W-1:0]   rd_addr,
    output logic [2*PROM_DW-1:0]    q
);

    logic               wr_2e;
    logic               wr_2f;
    logic [PROM_DW-1:0] q_2e;
    logic [PROM_DW-1:0] q_2f;

    // Route a download write to whichever PROM its high address byte names
    always_comb begin
        wr_2e = dl_wr && (dl_addr[15:8] == DL_HI_2E);
        wr_2f = dl_wr && (dl_addr[15:8] == DL_HI_2F);
    end

    dpram #(.AW(PAL_ADDR_W), .DW(PROM_DW)) u_prom_2e (
        .clk     (clk),
        .wr_en   (wr_2e),
        .wr_addr (dl_addr[7:0]),
        .wr_data (dl_data),
        .rd_addr (rd_addr),
        .rd_data (q_2e)
    );

    dpram #(.AW(PAL_ADDR_W), .DW(PROM_DW)) u_prom_2f (
        .clk     (clk),
        .wr_en   (wr_2f),
        .wr_addr (dl_addr[7:0]),
        .wr_data (dl_data),
        .rd_addr (rd_addr),
        .rd_data (q_2f)
    );

    assign q = {q_2e, q_2f};

endmodule

// File: rtl/dkong_dpram.sv
// rtl/dkong_dpram.sv - simple dual-port RAM, one write port and one registered read port
module dpram #(
    parameter int AW = 8,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    // Write port, driven by the download path only
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Synchronous read; a same-cycle write may return old data
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/dkong_pal_mix.sv
// rtl/dkong_pal_mix.sv - object/background priority, palette lookup and blanked RGB output
module dkong_pal_mix
    import dkong_pkg::*;
(
    input  logic              CLK_24M,
    input  logic              I_RST,
    input  logic              CLK_EN,
    input  logic [1:0]        I_VRAM_VID,
    input  logic [3:0]        I_VRAM_COL,
    input  logic [1:0]        I_OBJ_VID,
    input  logic [3:0]        I_OBJ_COL,
    input  logic [BANK_W-1:0] I_PAL_BANK,
    input  logic              I_VBLK,
    input  logic              I_CMPBLK,
    output logic [R_W-1:0]    O_R,
    output logic [G_W-1:0]    O_G,
    output logic [B_W-1:0]    O_B,
    output logic              O_BLKn,
    output logic [BANK_W-1:0] O_BANK,
    input  logic [15:0]       DL_ADDR,
    input  logic              DL_WR,
    input  logic [7:0]        DL_DATA
);

    logic                      obj_sel;
    logic [3:0]                col_mux;
    logic [1:0]                vid_mux;
    logic [PAL_ADDR_W-1:0]     pal_addr;
    logic                      blk1;
    logic                      vblk_prev;
    logic [BANK_W-1:0]         bank_r;
    logic [2*PROM_DW-1:0]      prom_q;
    logic [PROM_DW-1:0]        q_2e;
    logic [PROM_DW-1:0]        q_2f;
    logic [R_W-1:0]            r_next;
    logic [G_W-1:0]            g_next;
    logic [B_W-1:0]            b_next;
    logic                      unused_dl_data;

    assign unused_dl_data = ^DL_DATA[7:4];

    // Object wins whenever its code is non-zero; background code 0 still indexes colour 0
    always_comb begin
        obj_sel = |I_OBJ_VID;
        col_mux = obj_sel ? I_OBJ_COL : I_VRAM_COL;
        vid_mux = obj_sel ? I_OBJ_VID : I_VRAM_VID;
    end

    // Stage 1 address/blank capture and the vblank-edge bank latch
    always_ff @(posedge CLK_24M) begin
        if (I_RST) begin
            pal_addr  <= '0;
            blk1      <= 1'b0;
            vblk_prev <= 1'b0;
            bank_r    <= '0;
        end else if (CLK_EN) begin
            pal_addr  <= {bank_r, col_mux, vid_mux};
            blk1      <= I_CMPBLK;
            vblk_prev <= I_VBLK;
            if (I_VBLK && !vblk_prev) begin
                bank_r <= I_PAL_BANK;
            end
        end
    end

    dkong_col_prom u_col_prom (
        .clk     (CLK_24M),
        .dl_addr (DL_ADDR),
        .dl_wr   (DL_WR),
        .dl_data (DL_DATA[3:0]),
        .rd_addr (pal_addr),
        .q       (prom_q)
    );

    // PROM outputs are active-low colour bits
    always_comb begin
        q_2e   = prom_q[2*PROM_DW-1:PROM_DW];
        q_2f   = prom_q[PROM_DW-1:0];
        r_next = ~q_2e[3:1];
        g_next = {~q_2e[0], ~q_2f[3:2]};
        b_next = ~q_2f[1:0];
    end

    // Stage 3 output register, blanked while the delayed composite blank is low
    always_ff @(posedge CLK_24M) begin
        if (I_RST) begin
            O_R    <= '0;
            O_G    <= '0;
            O_B    <= '0;
            O_BLKn <= 1'b0;
        end else if (CLK_EN) begin
            O_BLKn <= blk1;
            if (blk1) begin
                O_R <= r_next;
                O_G <= g_next;
                O_B <= b_next;
            end else begin
                O_R <= '0;
                O_G <= '0;
                O_B <= '0;
            end
        end
    end

    assign O_BANK = bank_r;

endmodule
